// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU writeback stage: datapath and opcode
//   widths, opcode encodings, the writeback FSM state type, and a helper
//   that tells whether an opcode drains as two bus beats (ZLo then ZHi).
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam int DATA_W   = 32;
    localparam int OPCODE_W = 5;

    // Opcode encodings
    localparam logic [OPCODE_W-1:0] OP_AND  = 5'b00001;
    localparam logic [OPCODE_W-1:0] OP_OR   = 5'b00010;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPCODE_W-1:0] OP_SHR  = 5'b00101;
    localparam logic [OPCODE_W-1:0] OP_SHRA = 5'b00110;
    localparam logic [OPCODE_W-1:0] OP_SHL  = 5'b00111;
    localparam logic [OPCODE_W-1:0] OP_ROR  = 5'b01000;
    localparam logic [OPCODE_W-1:0] OP_ROL  = 5'b01001;
    localparam logic [OPCODE_W-1:0] OP_NEG  = 5'b01010;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 5'b01011;
    localparam logic [OPCODE_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b11010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2
    } wb_state_t;

    // mul and div produce a meaningful upper half that must go on the bus.
    function automatic logic is_two_beat(input logic [OPCODE_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/result_fifo.sv
// ---------------------------------------------------------------------------
// result_fifo
//   Small synchronous FIFO holding captured ALU results. The head entry is
//   presented combinationally on rd_data so the writeback FSM can put it on
//   the bus in the cycle right after it was pushed.
// Ports
//   clock    : clock, rising edge
//   clear    : asynchronous active-low reset (empties the FIFO)
//   push     : write wr_data (ignored when full)
//   pop      : discard head entry (ignored when empty)
//   wr_data  : entry to write
//   rd_data  : head entry (valid when !empty)
//   full     : DEPTH entries held
//   empty    : no entries held
//   count    : registered occupancy, 0..DEPTH
// ---------------------------------------------------------------------------
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 65
) (
    input  logic                     clock,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;

    logic push_ok;
    logic pop_ok;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr_reg];

    // Storage carries no reset; only occupancy bookkeeping is cleared.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + (PTR_W+1)'(1);
                2'b01:   count_reg <= count_reg - (PTR_W+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/alu_z_writeback.sv
// ---------------------------------------------------------------------------
// alu_z_writeback
//   Captures each 64-bit ALU result with its opcode into a small FIFO and
//   drains it onto the 32-bit bus as a ZLo beat, followed by a ZHi beat for
//   mul/div. When the final beat of a result is accepted, the architectural
//   zhi/zlo registers take the full result and result_cnt increments.
// Ports
//   clock       : clock, rising edge
//   clear       : asynchronous active-low reset
//   in_valid    : ALU result/opcode valid
//   in_ready    : stage can accept (FIFO not full, registered)
//   in_opcode   : opcode that produced in_result (nop is accepted and dropped)
//   in_result   : 64-bit ALU result C
//   bus_valid   : bus_data holds a beat
//   bus_ready   : bus consumes the beat when bus_valid & bus_ready
//   bus_data    : beat payload
//   bus_hi      : 0 = ZLo beat, 1 = ZHi beat
//   bus_last    : final beat of the current result
//   zhi, zlo    : architectural Z halves
//   result_cnt  : results fully drained since reset (wraps)
// ---------------------------------------------------------------------------
module alu_z_writeback #(
    parameter int DEPTH    = 2,
    parameter int DATA_W   = 32,
    parameter int OPCODE_W = 5
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [OPCODE_W-1:0]   in_opcode,
    input  logic [2*DATA_W-1:0]   in_result,
    output logic                  bus_valid,
    input  logic                  bus_ready,
    output logic [DATA_W-1:0]     bus_data,
    output logic                  bus_hi,
    output logic                  bus_last,
    output logic [DATA_W-1:0]     zhi,
    output logic [DATA_W-1:0]     zlo,
    output logic [15:0]           result_cnt
);

    import alu_pkg::*;

    localparam int CNT_W   = $clog2(DEPTH) + 1;
    localparam int ENTRY_W = 2*DATA_W + 1;

    wb_state_t state_reg;
    wb_state_t state_next;

    logic [DATA_W-1:0] zhi_reg;
    logic [DATA_W-1:0] zlo_reg;
    logic [15:0]       result_cnt_reg;

    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [ENTRY_W-1:0] fifo_wr_data;
    logic [ENTRY_W-1:0] fifo_rd_data;

    logic              push;
    logic              pop;
    logic              done;
    logic              head_two_beat;
    logic [DATA_W-1:0] head_lo;
    logic [DATA_W-1:0] head_hi;
    logic              more_after_pop;

    // in_ready comes only from the registered FIFO count, never from bus_ready.
    assign in_ready     = !fifo_full;
    assign push         = in_valid && in_ready && (in_opcode != OP_NOP);
    assign fifo_wr_data = {is_two_beat(in_opcode), in_result};

    assign head_two_beat = fifo_rd_data[ENTRY_W-1];
    assign head_lo       = fifo_rd_data[DATA_W-1:0];
    assign head_hi       = fifo_rd_data[2*DATA_W-1:DATA_W];

    // Another result is ready for the next cycle if one remains behind the
    // head or one is being pushed right now; this removes the bubble between
    // back-to-back results.
    assign more_after_pop = (fifo_count > CNT_W'(1)) || push;

    result_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_result_fifo (
        .clock   (clock),
        .clear   (clear),
        .push    (push),
        .pop     (pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Bus outputs depend only on state and the FIFO head, both of which only
    // change on an accepted beat, so a stalled beat never changes.
    always_comb begin
        state_next = state_reg;
        bus_valid  = 1'b0;
        bus_hi     = 1'b0;
        bus_last   = 1'b0;
        bus_data   = '0;
        pop        = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                // Entering LO on the push itself gives bus_valid the cycle after.
                if (push || !fifo_empty) begin
                    state_next = LO;
                end
            end
            LO: begin
                bus_valid = 1'b1;
                bus_last  = !head_two_beat;
                bus_data  = head_lo;
                if (bus_ready) begin
                    if (head_two_beat) begin
                        state_next = HI;
                    end else begin
                        pop        = 1'b1;
                        done       = 1'b1;
                        state_next = more_after_pop ? LO : IDLE;
                    end
                end
            end
            HI: begin
                bus_valid = 1'b1;
                bus_hi    = 1'b1;
                bus_last  = 1'b1;
                bus_data  = head_hi;
                if (bus_ready) begin
                    pop        = 1'b1;
                    done       = 1'b1;
                    state_next = more_after_pop ? LO : IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            zhi_reg        <= '0;
            zlo_reg        <= '0;
            result_cnt_reg <= '0;
        end else if (done) begin
            zhi_reg        <= head_hi;
            zlo_reg        <= head_lo;
            result_cnt_reg <= result_cnt_reg + 16'd1;
        end
    end

    assign zhi        = zhi_reg;
    assign zlo        = zlo_reg;
    assign result_cnt = result_cnt_reg;

endmodule

// File: tb/tb_alu_z_writeback.sv
// ---------------------------------------------------------------------------
// tb_alu_z_writeback
//   Drives directed and random ALU results into alu_z_writeback and compares
//   every cycle against a queue-based model: pending results wait in a list,
//   the head result exposes beat 0 (low half) then beat 1 (high half, mul/div
//   only), and the Z registers and completion count update as each result
//   finishes.
// ---------------------------------------------------------------------------
module tb_alu_z_writeback;

    localparam int DEPTH = 2;

    localparam logic [4:0] OP_AND = 5'b00001;
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHL = 5'b00111;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_MUL = 5'b10000;
    localparam logic [4:0] OP_NOP = 5'b11010;

    logic        clock = 1'b0;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_opcode = '0;
    logic [63:0] in_result = '0;
    logic        bus_valid;
    logic        bus_ready = 1'b0;
    logic [31:0] bus_data;
    logic        bus_hi;
    logic        bus_last;
    logic [31:0] zhi;
    logic [31:0] zlo;
    logic [15:0] result_cnt;

    always #5 clock = ~clock;

    alu_z_writeback #(
        .DEPTH    (DEPTH),
        .DATA_W   (32),
        .OPCODE_W (5)
    ) dut (
        .clock      (clock),
        .clear      (clear),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_result  (in_result),
        .bus_valid  (bus_valid),
        .bus_ready  (bus_ready),
        .bus_data   (bus_data),
        .bus_hi     (bus_hi),
        .bus_last   (bus_last),
        .zhi        (zhi),
        .zlo        (zlo),
        .result_cnt (result_cnt)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic [63:0] res;
        bit          two;
    } res_t;

    res_t        rq[$];
    int          beat_idx;
    logic [31:0] m_zhi;
    logic [31:0] m_zlo;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        rq.delete();
        beat_idx = 0;
        m_zhi    = '0;
        m_zlo    = '0;
        m_cnt    = '0;
    endtask

    task automatic check_outputs();
        logic [31:0] exp_data;
        check("in_ready", in_ready, rq.size() < DEPTH);
        check("bus_valid", bus_valid, rq.size() > 0);
        if (rq.size() > 0) begin
            exp_data = (beat_idx == 0) ? rq[0].res[31:0] : rq[0].res[63:32];
            check("bus_data", bus_data, exp_data);
            check("bus_hi", bus_hi, beat_idx == 1);
            check("bus_last", bus_last, !rq[0].two || beat_idx == 1);
        end
        check("zlo", zlo, m_zlo);
        check("zhi", zhi, m_zhi);
        check("result_cnt", result_cnt, m_cnt);
    endtask

    // One clock: check at the negedge, drive inputs, advance the model by what
    // the coming rising edge does, then move on to the next negedge.
    task automatic cycle(input bit iv, input logic [4:0] op, input logic [63:0] res,
                         input bit br, output bit accepted);
        res_t e;
        check_outputs();
        in_valid  = iv;
        in_opcode = op;
        in_result = res;
        bus_ready = br;
        accepted  = iv && (rq.size() < DEPTH);
        if (br && rq.size() > 0) begin
            $display("[TB] beat data=%h hi=%0d last=%0d", (beat_idx == 0) ? rq[0].res[31:0] : rq[0].res[63:32],
                     beat_idx, (!rq[0].two || beat_idx == 1));
            if (rq[0].two && beat_idx == 0) begin
                beat_idx = 1;
            end else begin
                m_zlo    = rq[0].res[31:0];
                m_zhi    = rq[0].res[63:32];
                m_cnt    = m_cnt + 16'd1;
                beat_idx = 0;
                void'(rq.pop_front());
            end
        end
        if (accepted && op != OP_NOP) begin
            e.res = res;
            e.two = (op == OP_MUL) || (op == OP_DIV);
            rq.push_back(e);
        end
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic idle(input int n, input bit br);
        bit a;
        for (int i = 0; i < n; i++) begin
            cycle(1'b0, OP_ADD, 64'h0, br, a);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          acc;
        logic [15:0] cnt_before;
        logic [4:0]  ops [7];
        ops[0] = OP_ADD; ops[1] = OP_SUB; ops[2] = OP_AND; ops[3] = OP_MUL;
        ops[4] = OP_DIV; ops[5] = OP_NOP; ops[6] = OP_SHL;

        model_reset();
        repeat (2) @(negedge clock);
        check_outputs();
        check("rst_bus_data", bus_data, 32'h0);
        check("rst_bus_hi", bus_hi, 1'b0);
        check("rst_bus_last", bus_last, 1'b0);
        clear = 1'b1;
        @(negedge clock);

        // add: single ZLo beat, zhi still loaded
        cycle(1'b1, OP_ADD, 64'hFFFF_FFFF_8000_0001, 1'b1, acc);
        idle(3, 1'b1);
        check("t2_zlo", zlo, 32'h8000_0001);
        check("t2_zhi", zhi, 32'hFFFF_FFFF);
        check("t2_cnt", result_cnt, 16'd1);

        // mul: two beats
        cycle(1'b1, OP_MUL, 64'h0000_0012_3456_789A, 1'b1, acc);
        idle(4, 1'b1);
        check("t3_zhi", zhi, 32'h0000_0012);

        // backpressure with three mul results
        cnt_before = m_cnt;
        cycle(1'b1, OP_MUL, 64'h1111_1111_AAAA_AAAA, 1'b0, acc);
        cycle(1'b1, OP_MUL, 64'h2222_2222_BBBB_BBBB, 1'b0, acc);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, OP_MUL, 64'h3333_3333_CCCC_CCCC, 1'b0, acc);
        end
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) begin
            cycle(1'b1, OP_MUL, 64'h3333_3333_CCCC_CCCC, 1'b1, acc);
        end
        check("t4_third_accepted", acc, 1'b1);
        idle(8, 1'b1);
        check("t4_cnt", result_cnt, cnt_before + 16'd3);

        // nop: dropped entirely
        cnt_before = m_cnt;
        cycle(1'b1, OP_NOP, 64'hDEAD, 1'b1, acc);
        idle(3, 1'b1);
        check("t5_cnt", result_cnt, cnt_before);

        // reset during the ZHi beat
        cycle(1'b1, OP_MUL, 64'h5555_6666_7777_8888, 1'b1, acc);
        cycle(1'b0, OP_ADD, 64'h0, 1'b1, acc);
        check_outputs();
        check("t1_in_hi", bus_hi, 1'b1);
        #2;
        clear = 1'b0;
        #1;
        model_reset();
        check("t1_bus_valid", bus_valid, 1'b0);
        check("t1_in_ready", in_ready, 1'b1);
        check("t1_zhi", zhi, 32'h0);
        check("t1_zlo", zlo, 32'h0);
        check("t1_cnt", result_cnt, 16'h0);
        check("t1_bus_data", bus_data, 32'h0);
        @(negedge clock);
        clear = 1'b1;
        idle(2, 1'b1);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), ops[$urandom_range(0, 6)],
                  {$urandom, $urandom}, ($urandom_range(0, 9) < 7), acc);
        end
        idle(6, 1'b1);

        // counter wrap
        force dut.result_cnt_reg = 16'hFFFF;
        @(posedge clock);
        @(negedge clock);
        release dut.result_cnt_reg;
        m_cnt = 16'hFFFF;
        cycle(1'b1, OP_ADD, 64'h0000_0001_0000_0002, 1'b1, acc);
        idle(3, 1'b1);
        check("t6_cnt_wrap", result_cnt, 16'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
